// File: rtl/flipping_pkg.sv
// Shared constants and helpers for the flipping (bus-invert) datapath.
package flipping_pkg;

  localparam int unsigned N_DEFAULT     = 16;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Threshold for the default width; above it the word is inverted.
  localparam int unsigned FLIP_THRESHOLD_DEFAULT = N_DEFAULT / 2;

  // Select applied to the word entering the output register.
  typedef enum logic {
    FLIP_PASS   = 1'b0,
    FLIP_INVERT = 1'b1
  } flip_sel_e;

  // Width needed to hold a Hamming distance in 0..n.
  function automatic int unsigned hd_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Strictly-greater threshold: a tie at n/2 does not flip.
  function automatic int unsigned flip_threshold(input int unsigned n);
    return n / 2;
  endfunction

endpackage

// File: rtl/contador_unos.sv
// Combinational population count of an N-bit word.
module contador_unos
  import flipping_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0]             i_data,
  output logic [hd_width(N)-1:0]   o_count
);

  localparam int unsigned W = hd_width(N);

  // Sum of all set bits.
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_count = o_count + {{(W-1){1'b0}}, i_data[i]};
    end
  end

endmodule

// File: rtl/codificador_flipping.sv
// Bus-invert encoder: inverts a word when that reduces output-bus toggles
// below half, registers it one-deep with a flip flag, and keeps saturating
// statistics of words sent and words flipped.
module codificador_flipping
  import flipping_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             en_flip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_flip,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] flip_count
);

  localparam int unsigned     HD_W   = hd_width(N);
  localparam logic [HD_W-1:0] THRESH = HD_W'(flip_threshold(N));

  logic [N-1:0]     r_data;
  logic             r_flip;
  logic             r_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_flip_cnt;

  logic [N-1:0]     w_diff;
  logic [HD_W-1:0]  w_hd;
  logic             w_load;
  flip_sel_e        w_sel;
  logic [N-1:0]     w_enc;

  // The held output word is the reference, so toggles are measured against
  // exactly what the bus last carried (including after it drained).
  assign w_diff = in_data ^ r_data;

  contador_unos #(.N(N)) u_contador_unos (
    .i_data  (w_diff),
    .o_count (w_hd)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  // Flip decision and encoded word.
  always_comb begin
    w_sel = FLIP_PASS;
    if (en_flip && (w_hd > THRESH)) begin
      w_sel = FLIP_INVERT;
    end
    w_enc = (w_sel == FLIP_INVERT) ? ~in_data : in_data;
  end

  // One-deep output register; data and flag hold after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_flip  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_enc;
      r_flip  <= (w_sel == FLIP_INVERT);
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating statistics; clear wins over a same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_flip_cnt <= '0;
    end else if (clear_stats) begin
      r_word_cnt <= '0;
      r_flip_cnt <= '0;
    end else if (w_load) begin
      if (r_word_cnt != '1) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if ((w_sel == FLIP_INVERT) && (r_flip_cnt != '1)) begin
        r_flip_cnt <= r_flip_cnt + CNT_W'(1);
      end
    end
  end

  assign out_data   = r_data;
  assign out_flip   = r_flip;
  assign out_valid  = r_valid;
  assign word_count = r_word_cnt;
  assign flip_count = r_flip_cnt;

endmodule
